// File: rtl/data_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Fixed latency: grant edge -> ACCESS cycle (Ack + memory strobe) -> RESP cycle (read data).
module data_memory_arbiter #(
  parameter int MEMWIDTH = 32,
  parameter int ADDSIZE  = 6
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                AReq,
  input  logic                BReq,
  input  logic                AWrite,
  input  logic                BWrite,
  input  logic [ADDSIZE-1:0]  AAddress,
  input  logic [ADDSIZE-1:0]  BAddress,
  input  logic [MEMWIDTH-1:0] AWriteData,
  input  logic [MEMWIDTH-1:0] BWriteData,
  output logic                AAck,
  output logic                BAck,
  output logic                ARdValid,
  output logic                BRdValid,
  output logic [MEMWIDTH-1:0] RdData,
  output logic [ADDSIZE-1:0]  MemAddress,
  output logic [MEMWIDTH-1:0] MemWriteData,
  output logic                MemoryRead,
  output logic                MemoryWrite,
  input  logic [MEMWIDTH-1:0] MemReadData,
  output logic                Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic                grant, win_b, sel_write;
  logic                last_b, owner_b, wr_q;
  logic [MEMWIDTH-1:0] rd_hold;

  always_comb begin
    grant     = 1'b0;
    win_b     = 1'b0;
    sel_write = AWrite;
    state_nxt = state;
    case (state)
      IDLE: if (AReq || BReq) begin
        grant     = 1'b1;
        // B wins outright, or on a tie when A was granted last
        win_b     = BReq && (!AReq || !last_b);
        sel_write = win_b ? BWrite : AWrite;
        state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = wr_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_b       <= 1'b1;
      owner_b      <= 1'b0;
      wr_q         <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      AAck         <= 1'b0;
      BAck         <= 1'b0;
      ARdValid     <= 1'b0;
      BRdValid     <= 1'b0;
      rd_hold      <= '0;
    end else begin
      MemoryRead  <= 1'b0;
      MemoryWrite <= 1'b0;
      AAck        <= 1'b0;
      BAck        <= 1'b0;
      ARdValid    <= 1'b0;
      BRdValid    <= 1'b0;
      if (grant) begin
        last_b       <= win_b;
        owner_b      <= win_b;
        wr_q         <= sel_write;
        MemAddress   <= win_b ? BAddress : AAddress;
        MemWriteData <= win_b ? BWriteData : AWriteData;
        MemoryWrite  <= sel_write;
        MemoryRead   <= !sel_write;
        AAck         <= !win_b;
        BAck         <= win_b;
      end
      if (state == ACCESS && !wr_q) begin
        ARdValid <= !owner_b;
        BRdValid <= owner_b;
      end
      // memory data is only valid during RESP; keep it for the hold period
      if (state == RESP) rd_hold <= MemReadData;
    end
  end

  assign RdData = (state == RESP) ? MemReadData : rd_hold;
  assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed + random bench for data_memory_arbiter with a transaction-schedule reference model
// and a registered-read 64-word memory behind the arbiter.
module tb_data_memory_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        AReq, BReq, AWrite, BWrite;
  logic [5:0]  AAddress, BAddress;
  logic [31:0] AWriteData, BWriteData;
  logic        AAck, BAck, ARdValid, BRdValid;
  logic [31:0] RdData;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData;
  logic        MemoryRead, MemoryWrite;
  logic [31:0] MemReadData = '0;
  logic        Busy;

  data_memory_arbiter #(.MEMWIDTH(32), .ADDSIZE(6)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .AReq(AReq), .BReq(BReq), .AWrite(AWrite), .BWrite(BWrite),
    .AAddress(AAddress), .BAddress(BAddress),
    .AWriteData(AWriteData), .BWriteData(BWriteData),
    .AAck(AAck), .BAck(BAck), .ARdValid(ARdValid), .BRdValid(BRdValid),
    .RdData(RdData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .MemReadData(MemReadData), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // memory: registered read on the edge that samples MemoryRead
  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge Clock) begin
    if (MemoryWrite) mem[MemAddress] <= MemWriteData;
    if (MemoryRead)  MemReadData <= mem[MemAddress];
  end

  int checks = 0;
  int errors = 0;

  // reference model: a grant at edge g schedules ACCESS in cycle g and, for reads, RESP in g+1
  logic [31:0] shadow [64];
  int          k, busy_end, acc_cyc, resp_cyc;
  logic        m_win_b, m_last_a, m_wr;
  logic [5:0]  e_addr;
  logic [31:0] e_wdata, e_rd, rd_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy_end = k; acc_cyc = -1; resp_cyc = -1;
    m_last_a = 1'b0; m_win_b = 1'b0; m_wr = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd = '0;
  endtask

  task automatic model_edge();
    k++;
    if (k > busy_end && (AReq || BReq)) begin
      m_win_b  = BReq && (!AReq || m_last_a);
      m_last_a = !m_win_b;
      m_wr     = m_win_b ? BWrite : AWrite;
      e_addr   = m_win_b ? BAddress : AAddress;
      e_wdata  = m_win_b ? BWriteData : AWriteData;
      acc_cyc  = k;
      resp_cyc = m_wr ? -1 : k + 1;
      busy_end = m_wr ? k + 1 : k + 2;
      if (m_wr) shadow[e_addr] = e_wdata;
      else      rd_val = shadow[e_addr];
    end
    if (resp_cyc == k) e_rd = rd_val;
  endtask

  task automatic compare();
    logic acc, rsp;
    acc = (acc_cyc == k);
    rsp = (resp_cyc == k);
    check("AAck",         AAck,         acc && !m_win_b);
    check("BAck",         BAck,         acc && m_win_b);
    check("MemoryWrite",  MemoryWrite,  acc && m_wr);
    check("MemoryRead",   MemoryRead,   acc && !m_wr);
    check("MemAddress",   MemAddress,   e_addr);
    check("MemWriteData", MemWriteData, e_wdata);
    check("ARdValid",     ARdValid,     rsp && !m_win_b);
    check("BRdValid",     BRdValid,     rsp && m_win_b);
    check("RdData",       RdData,       e_rd);
    check("Busy",         Busy,         k < busy_end);
  endtask

  task automatic step();
    @(posedge Clock);
    if (Resetn) model_edge();
    #1;
    if (Resetn) compare();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, {AAck, BAck, ARdValid, BRdValid, MemoryRead, MemoryWrite, Busy}, 0);
    check({tag, "_addr"}, MemAddress, 0);
    check({tag, "_wdata"}, MemWriteData, 0);
    check({tag, "_rd"}, RdData, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    k = 0; rd_val = '0;
    model_reset();
    Resetn = 1'b0;
    AReq = 0; BReq = 0; AWrite = 0; BWrite = 0;
    AAddress = 0; BAddress = 0; AWriteData = 0; BWriteData = 0;
    #12;
    check_zero("reset");
    @(negedge Clock);
    Resetn = 1'b1;

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) step();
    check("idle_busy", Busy, 0);

    // single write by A, then B reads it back
    AReq = 1; AWrite = 1; AAddress = 6'd5; AWriteData = 32'hDEADBEEF;
    step();
    check("wr_aack", AAck, 1);
    check("wr_memwrite", MemoryWrite, 1);
    check("wr_memaddr", MemAddress, 5);
    AReq = 0;
    step();
    BReq = 1; BWrite = 0; BAddress = 6'd5;
    step();
    check("rd_back", BAck, 1);
    check("rd_noval", BRdValid, 0);
    BReq = 0;
    step();
    check("rd_bval", BRdValid, 1);
    check("rd_data", RdData, 32'hDEADBEEF);
    step();
    check("rd_busy_done", Busy, 0);
    check("rd_bval_off", BRdValid, 0);
    check("rd_data_hold", RdData, 32'hDEADBEEF);

    // continuous tie: grants alternate
    AReq = 1; BReq = 1; AWrite = 1; BWrite = 1;
    AAddress = 6'd10; BAddress = 6'd11; AWriteData = 32'h1111; BWriteData = 32'h2222;
    for (int i = 0; i < 8; i++) step();
    AReq = 0; BReq = 0;
    step();

    // input change after latch does not affect the access
    AReq = 1; AWrite = 1; AAddress = 6'd3; AWriteData = 32'h33;
    step();
    AAddress = 6'd9; AWriteData = 32'h99;
    #2;
    check("latch_addr", MemAddress, 3);
    check("latch_data", MemWriteData, 32'h33);
    AReq = 0;
    step();

    // reset during a read ACCESS aborts it
    BReq = 1; BWrite = 0; BAddress = 6'd3;
    step();
    check("rst_pre_back", BAck, 1);
    BReq = 0;
    #2 Resetn = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    step(); step();
    check("midrst_noval", {ARdValid, BRdValid}, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_busy", Busy, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      AReq = ($urandom_range(0, 3) != 0);
      BReq = ($urandom_range(0, 3) != 0);
      AWrite = $urandom_range(0, 1);
      BWrite = $urandom_range(0, 1);
      AAddress = 6'($urandom_range(0, 7));
      BAddress = 6'($urandom_range(0, 7));
      AWriteData = $urandom;
      BWriteData = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
